multicycle_controller: RTL and testbench

Control unit for the multicycle ARMv4 core. It takes the instruction fields latched in the instruction register and sequences fetch, decode, execute, memory and write-back over several cycles. It drives the datapath muxes, including the `ImmSrc` select of the `Extend` unit, and owns the NZCV condition-flag register. Writes to the PC, register file and data memory are gated by the instruction's condition code.

---
 rtl/multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4 control unit: main FSM with registered datapath controls,
// ALU decoder, NZCV flag register and condition-code gating of the write enables.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecuteR,
        StExecuteI,
        StAluWb,
        StBranch
    } stateT;

    // Raw per-state controls, before condition gating.
    typedef struct packed {
        logic       adrSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       irWrite;
        logic       nextPc;
        logic       regW;
        logic       memW;
        logic       branch;
        logic       aluOp;
    } ctrlT;

    stateT      state;
    stateT      nextState;
    ctrlT       ctrl;
    ctrlT       act;
    logic [3:0] flags;      // {N, Z, C, V}
    logic       condEx;
    logic       condExReg;
    logic [3:0] cmd;
    logic [1:0] flagW;
    logic       noWrite;

    // Control word asserted while the FSM sits in a given state.
    function automatic ctrlT ctrlOf(input stateT s);
        ctrlT c;
        c = '0;
        case (s)
            StFetch: begin
                c.aluSrcA   = 2'b01;
                c.aluSrcB   = 2'b10;
                c.resultSrc = 2'b10;
                c.irWrite   = 1'b1;
                c.nextPc    = 1'b1;
            end
            StDecode: begin
                c.aluSrcA   = 2'b01;
                c.aluSrcB   = 2'b10;
                c.resultSrc = 2'b10;
            end
            StMemAdr: begin
                c.aluSrcB   = 2'b01;
            end
            StMemRead: begin
                c.adrSrc    = 1'b1;
            end
            StMemWb: begin
                c.resultSrc = 2'b01;
                c.regW      = 1'b1;
            end
            StMemWrite: begin
                c.adrSrc    = 1'b1;
                c.memW      = 1'b1;
            end
            StExecuteR: begin
                c.aluOp     = 1'b1;
            end
            StExecuteI: begin
                c.aluSrcB   = 2'b01;
                c.aluOp     = 1'b1;
            end
            StAluWb: begin
                c.regW      = 1'b1;
            end
            StBranch: begin
                c.aluSrcB   = 2'b01;
                c.resultSrc = 2'b10;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state sequencing from the current state and instruction fields.
    always_comb begin
        nextState = StFetch;
        case (state)
            StFetch: nextState = StDecode;
            StDecode: begin
                unique case (Op)
                    2'b00: nextState = Funct[5] ? StExecuteI : StExecuteR;
                    2'b01: nextState = StMemAdr;
                    2'b10: nextState = StBranch;
                    2'b11: nextState = StFetch;
                endcase
            end
            StMemAdr:   nextState = Funct[0] ? StMemRead : StMemWrite;
            StMemRead:  nextState = StMemWb;
            StExecuteR: nextState = StAluWb;
            StExecuteI: nextState = StAluWb;
            default:    nextState = StFetch;
        endcase
    end

    // Condition check against the stored flags.
    always_comb begin
        condEx = 1'b0;
        case (Cond)
            4'b0000: condEx = flags[2];
            4'b0001: condEx = ~flags[2];
            4'b0010: condEx = flags[1];
            4'b0011: condEx = ~flags[1];
            4'b0100: condEx = flags[3];
            4'b0101: condEx = ~flags[3];
            4'b0110: condEx = flags[0];
            4'b0111: condEx = ~flags[0];
            4'b1000: condEx = flags[1] & ~flags[2];
            4'b1001: condEx = ~flags[1] | flags[2];
            4'b1010: condEx = (flags[3] == flags[0]);
            4'b1011: condEx = (flags[3] != flags[0]);
            4'b1100: condEx = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condEx = flags[2] | (flags[3] != flags[0]);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    // While reset is held the datapath sees the FETCH controls.
    always_comb begin
        act = reset ? ctrlOf(StFetch) : ctrl;
    end

    // ALU decoder and flag-write enables.
    always_comb begin
        cmd        = Funct[4:1];
        ALUControl = 2'b00;
        flagW      = 2'b00;
        if (act.aluOp) begin
            case (cmd)
                4'b0100: ALUControl = 2'b00;
                4'b0010: ALUControl = 2'b01;
                4'b0000: ALUControl = 2'b10;
                4'b1100: ALUControl = 2'b11;
                4'b1010: ALUControl = 2'b01;
                default: ALUControl = 2'b00;
            endcase
            flagW[1] = Funct[0];
            flagW[0] = Funct[0] & ((cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010));
        end
        // Decoded from the fields, not ALUOp, so it still holds in ALUWB.
        noWrite = (Op == 2'b00) && (cmd == 4'b1010);
    end

    // State, registered controls, condition latch and NZCV register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StFetch;
            ctrl      <= ctrlOf(StFetch);
            flags     <= 4'b0000;
            condExReg <= 1'b0;
        end else begin
            state <= nextState;
            ctrl  <= ctrlOf(nextState);
            if (state == StDecode) begin
                condExReg <= condEx;
            end
            if (ctrl.aluOp) begin
                if (flagW[1] && condExReg) begin
                    flags[3:2] <= ALUFlags[3:2];
                end
                if (flagW[0] && condExReg) begin
                    flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

    // Gated write enables and field-derived selects.
    always_comb begin
        PCWrite   = ~reset & (act.nextPc | (act.branch & condExReg));
        RegWrite  = ~reset & act.regW & condExReg & ~noWrite;
        MemWrite  = ~reset & act.memW & condExReg;
        IRWrite   = ~reset & act.irWrite;
        AdrSrc    = act.adrSrc;
        ALUSrcA   = act.aluSrcA;
        ALUSrcB   = act.aluSrcB;
        ResultSrc = act.resultSrc;
        ImmSrc    = Op;
        RegSrc    = {Op == 2'b01, Op == 2'b10};
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller: each issued instruction
// pushes its expected per-cycle control vectors; a monitor pops one per cycle.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [16:0] dutVec;

    int tests = 0;
    int fails = 0;

    logic [16:0] expQ[$];
    string       nameQ[$];
    logic [3:0]  mFlags;   // reference {N,Z,C,V}

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    assign dutVec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                     ResultSrc, ImmSrc, RegSrc, ALUControl};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic condOk(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] aluFor(input logic [3:0] c);
        case (c)
            4'd4:  return 2'b00;
            4'd2:  return 2'b01;
            4'd0:  return 2'b10;
            4'd12: return 2'b11;
            4'd10: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic pushV(input string nm, input logic pcw, input logic memw, input logic regw,
                         input logic irw, input logic adr, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] res, input logic [1:0] alu);
        logic [1:0] regSrc;
        regSrc = {Op == 2'b01, Op == 2'b10};
        expQ.push_back({pcw, memw, regw, irw, adr, a, b, res, Op, regSrc, alu});
        nameQ.push_back(nm);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected trace of one whole instruction; abortAfter > 0 cuts it short with reset.
    task automatic issue(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] af, input string tag, input int abortAfter);
        logic       ce;
        logic [3:0] cm;
        logic       arith;
        int         n;
        Cond = c; Op = o; Funct = f; ALUFlags = af;
        ce = condOk(c, mFlags);
        cm = f[4:1];
        arith = (cm == 4'd4) || (cm == 4'd2) || (cm == 4'd10);
        n = 2;
        pushV({tag, ".fetch"}, 1, 0, 0, 1, 0, 2'b01, 2'b10, 2'b10, 2'b00);
        pushV({tag, ".decode"}, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
        case (o)
            2'b01: begin
                pushV({tag, ".memadr"}, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00);
                n++;
                if (abortAfter > 0) begin
                    waitCycles(n);
                    reset = 1'b1;
                    pushV({tag, ".rst0"}, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                    pushV({tag, ".rst1"}, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
                    waitCycles(2);
                    reset = 1'b0;
                    mFlags = 4'b0000;
                    return;
                end
                if (f[0]) begin
                    pushV({tag, ".memread"}, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
                    pushV({tag, ".memwb"}, 0, 0, ce, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00);
                    n += 2;
                end else begin
                    pushV({tag, ".memwrite"}, 0, ce, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
                    n++;
                end
            end
            2'b00: begin
                pushV({tag, ".execute"}, 0, 0, 0, 0, 0, 2'b00, {1'b0, f[5]}, 2'b00, aluFor(cm));
                pushV({tag, ".aluwb"}, 0, 0, ce && (cm != 4'd10), 0, 0, 2'b00, 2'b00, 2'b00,
                      2'b00);
                n += 2;
                if (ce && f[0]) mFlags[3:2] = af[3:2];
                if (ce && f[0] && arith) mFlags[1:0] = af[1:0];
            end
            2'b10: begin
                pushV({tag, ".branch"}, ce, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
                n++;
            end
            default: ;
        endcase
        waitCycles(n);
    endtask

    // Monitor: one comparison per cycle while expectations are pending.
    initial begin
        logic [16:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                nm = nameQ.pop_front();
                tests++;
                if (dutVec !== e) begin
                    fails++;
                    $display("FAIL %s got %b exp %b", nm, dutVec, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmdSet [6];
        logic [3:0] rc;
        logic [1:0] ro;
        logic [5:0] rf;
        int         w;
        cmdSet[0] = 4'd4; cmdSet[1] = 4'd2; cmdSet[2] = 4'd0;
        cmdSet[3] = 4'd12; cmdSet[4] = 4'd10; cmdSet[5] = 4'd7;
        mFlags = 4'b0000;
        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; ALUFlags = 4'd0;
        @(posedge clk); #1;
        pushV("reset.hold", 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00);
        waitCycles(1);
        reset = 1'b0;

        issue(4'hE, 2'b00, 6'b001000, 4'b0000, "add", 0);
        issue(4'hE, 2'b01, 6'b011001, 4'b0000, "ldr", 0);
        issue(4'hE, 2'b01, 6'b011000, 4'b0000, "str", 0);
        issue(4'hE, 2'b00, 6'b000101, 4'b0100, "subs.z", 0);
        issue(4'h0, 2'b10, 6'b000000, 4'b0000, "beq.taken", 0);
        issue(4'hE, 2'b00, 6'b000101, 4'b0000, "subs.nz", 0);
        issue(4'h0, 2'b10, 6'b000000, 4'b0000, "beq.not", 0);
        issue(4'hE, 2'b00, 6'b010101, 4'b1000, "cmp", 0);
        issue(4'h4, 2'b10, 6'b000000, 4'b0000, "bmi", 0);
        issue(4'h0, 2'b00, 6'b001000, 4'b0000, "addeq.skip", 0);
        issue(4'hE, 2'b01, 6'b011001, 4'b0000, "ldr.abort", 1);
        issue(4'h0, 2'b10, 6'b000000, 4'b0000, "beq.afterrst", 0);
        issue(4'h1, 2'b10, 6'b000000, 4'b0000, "bne.afterrst", 0);
        issue(4'h2, 2'b10, 6'b000000, 4'b0000, "bcs.afterrst", 0);
        issue(4'hE, 2'b11, 6'b111111, 4'b0000, "undef", 0);
        issue(4'hF, 2'b10, 6'b000000, 4'b0000, "bnv", 0);

        for (int i = 0; i < 300; i++) begin
            rc = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            rf = 6'($urandom_range(0, 63));
            if (ro == 2'b00) rf[4:1] = cmdSet[$urandom_range(0, 5)];
            issue(rc, ro, rf, 4'($urandom_range(0, 15)), "rand",
                  (ro == 2'b01 && $urandom_range(0, 19) == 0) ? 1 : 0);
        end

        w = 0;
        while (expQ.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
